// File: rtl/dsp_file_store.sv
// dsp_file_store: multi-file circular word store for the DSP equation engines.
// It holds NUM_FILES independent FIFOs ("files") of DEPTH words each.
//
// Engine port: file_num/file_read/file_write/file_write_data request a single
// read or write. The store answers with a two-cycle file_active window, and a
// read returns its word on file_read_data.
//
// Host port: host_sel/host_push/host_pop/host_wdata request one op. The op is
// acknowledged with host_ack, and a pop returns its word on host_rdata.
// host_count is the combinational word count of file host_sel.
//
// error_status holds sticky flags: {protocol, bad file, underflow, overflow}.
// error_clear zeros them.
module dsp_file_store #(
  parameter int unsigned dw        = 32,
  parameter int unsigned NUM_FILES = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_write,
  input  logic          file_read,
  input  logic [dw-1:0] file_write_data,
  output logic [dw-1:0] file_read_data,
  output logic          file_active,
  input  logic [7:0]    host_sel,
  input  logic          host_push,
  input  logic          host_pop,
  input  logic [dw-1:0] host_wdata,
  output logic [dw-1:0] host_rdata,
  output logic          host_ack,
  output logic [CW-1:0] host_count,
  input  logic          error_clear,
  output logic [3:0]    error_status
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned FW        = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int unsigned MW        = FW + AW;
  localparam int unsigned MEM_WORDS = NUM_FILES * DEPTH;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    req_file_q, req_file_d;
  logic          req_write_q, req_write_d;
  logic [dw-1:0] req_wdata_q, req_wdata_d;
  logic          file_active_q, file_active_d;
  logic [dw-1:0] file_rdata_q, file_rdata_d;
  logic [dw-1:0] host_rdata_q, host_rdata_d;
  logic          host_ack_q, host_ack_d;
  logic [3:0]    error_q, error_d;

  logic [AW-1:0] wr_ptr_q [NUM_FILES];
  logic [AW-1:0] wr_ptr_d [NUM_FILES];
  logic [AW-1:0] rd_ptr_q [NUM_FILES];
  logic [AW-1:0] rd_ptr_d [NUM_FILES];
  logic [CW-1:0] count_q  [NUM_FILES];
  logic [CW-1:0] count_d  [NUM_FILES];

  logic [dw-1:0] mem_q [MEM_WORDS];
  logic          mem_we;
  logic [MW-1:0] mem_waddr;
  logic [dw-1:0] mem_wdata;

  logic          eng_req, eng_commit, host_accept;
  logic          op_valid, op_write, op_file_ok;
  logic [7:0]    op_file;
  logic [FW-1:0] op_idx;
  logic [dw-1:0] op_wdata, op_rword, rd_word;
  logic [3:0]    err_set;

  // Select the single op that commits this cycle. An engine commit (ACCESS)
  // and a host op (IDLE only) can never coincide.
  always_comb begin
    eng_req     = file_read | file_write;
    eng_commit  = (state_q == ACCESS);
    host_accept = (state_q == IDLE) && !eng_req && (host_push ^ host_pop);
    op_valid    = eng_commit | host_accept;
    op_write    = eng_commit ? req_write_q : host_push;
    op_file     = eng_commit ? req_file_q  : host_sel;
    op_wdata    = eng_commit ? req_wdata_q : host_wdata;
    op_file_ok  = ({1'b0, op_file} < 9'(NUM_FILES));
    op_idx      = FW'(op_file);
    op_rword    = mem_q[{op_idx, rd_ptr_q[op_idx]}];
  end

  // Engine FSM, FIFO bookkeeping and error flags.
  always_comb begin
    state_d      = state_q;
    req_file_d   = req_file_q;
    req_write_d  = req_write_q;
    req_wdata_d  = req_wdata_q;
    file_rdata_d = file_rdata_q;
    host_rdata_d = host_rdata_q;
    host_ack_d   = host_accept;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_set      = '0;
    rd_word      = '0;
    mem_we       = 1'b0;
    mem_waddr    = {op_idx, wr_ptr_q[op_idx]};
    mem_wdata    = op_wdata;

    unique case (state_q)
      IDLE: begin
        if (file_read ^ file_write) begin
          state_d     = ACCESS;
          req_file_d  = file_num;
          req_write_d = file_write;
          req_wdata_d = file_write_data;
        end else if (file_read && file_write) begin
          err_set[3] = 1'b1;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (eng_req) err_set[3] = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        if (eng_req) err_set[3] = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (host_push && host_pop) err_set[3] = 1'b1;

    if (op_valid) begin
      if (!op_file_ok) begin
        err_set[2] = 1'b1;
      end else if (op_write) begin
        if (count_q[op_idx] == FULL) begin
          err_set[0] = 1'b1;
        end else begin
          mem_we           = !wb_rst;
          wr_ptr_d[op_idx] = wr_ptr_q[op_idx] + AW'(1);
          count_d[op_idx]  = count_q[op_idx] + CW'(1);
        end
      end else begin
        if (count_q[op_idx] == '0) begin
          err_set[1] = 1'b1;
        end else begin
          rd_word          = op_rword;
          rd_ptr_d[op_idx] = rd_ptr_q[op_idx] + AW'(1);
          count_d[op_idx]  = count_q[op_idx] - CW'(1);
        end
      end
      // Reads return their word (or 0 on failure) to the requesting side.
      if (!op_write) begin
        if (eng_commit) file_rdata_d = rd_word;
        else            host_rdata_d = rd_word;
      end
    end

    file_active_d = (state_d != IDLE);
    // A new error in the same cycle as a clear still sets its bit.
    error_d = (error_clear ? 4'b0000 : error_q) | err_set;
  end

  always_comb begin
    host_count = '0;
    if ({1'b0, host_sel} < 9'(NUM_FILES)) host_count = count_q[FW'(host_sel)];
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q       <= IDLE;
      req_file_q    <= '0;
      req_write_q   <= 1'b0;
      req_wdata_q   <= '0;
      file_active_q <= 1'b0;
      file_rdata_q  <= '0;
      host_rdata_q  <= '0;
      host_ack_q    <= 1'b0;
      error_q       <= '0;
      for (int i = 0; i < int'(NUM_FILES); i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      req_file_q    <= req_file_d;
      req_write_q   <= req_write_d;
      req_wdata_q   <= req_wdata_d;
      file_active_q <= file_active_d;
      file_rdata_q  <= file_rdata_d;
      host_rdata_q  <= host_rdata_d;
      host_ack_q    <= host_ack_d;
      error_q       <= error_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Word storage; contents survive reset.
  always_ff @(posedge wb_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign file_read_data = file_rdata_q;
  assign file_active    = file_active_q;
  assign host_rdata     = host_rdata_q;
  assign host_ack       = host_ack_q;
  assign error_status   = error_q;

endmodule

// File: tb/tb_dsp_file_store.sv
module tb_dsp_file_store;

  logic        wb_clk;
  logic        wb_rst;
  logic [7:0]  file_num;
  logic        file_write;
  logic        file_read;
  logic [31:0] file_write_data;
  logic [31:0] file_read_data;
  logic        file_active;
  logic [7:0]  host_sel;
  logic        host_push;
  logic        host_pop;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic [4:0]  host_count;
  logic        error_clear;
  logic [3:0]  error_status;

  int vec_cnt = 0;
  int err_cnt = 0;

  dsp_file_store #(.dw(32), .NUM_FILES(4), .DEPTH(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .file_num(file_num), .file_write(file_write), .file_read(file_read),
    .file_write_data(file_write_data), .file_read_data(file_read_data),
    .file_active(file_active),
    .host_sel(host_sel), .host_push(host_push), .host_pop(host_pop),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_count(host_count),
    .error_clear(error_clear), .error_status(error_status)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic host_op(input logic push, input logic [7:0] sel, input logic [31:0] wd);
    host_sel   = sel;
    host_push  = push;
    host_pop   = !push;
    host_wdata = wd;
    tick();
    host_push  = 1'b0;
    host_pop   = 1'b0;
  endtask

  // Drive an engine request for one edge; returns in the ACCESS cycle.
  task automatic eng_start(input logic wr, input logic [7:0] f, input logic [31:0] d);
    file_num        = f;
    file_write      = wr;
    file_read       = !wr;
    file_write_data = d;
    tick();
    file_write = 1'b0;
    file_read  = 1'b0;
  endtask

  task automatic test_reset;
    wb_rst = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (file_active !== 1'b0) begin err_cnt++; $display("FAIL reset_active: got %b want 0", file_active); end
    vec_cnt++;
    if (file_read_data !== 32'h0) begin err_cnt++; $display("FAIL reset_frd: got %h want 0", file_read_data); end
    vec_cnt++;
    if (host_rdata !== 32'h0) begin err_cnt++; $display("FAIL reset_hrd: got %h want 0", host_rdata); end
    vec_cnt++;
    if (host_ack !== 1'b0) begin err_cnt++; $display("FAIL reset_ack: got %b want 0", host_ack); end
    vec_cnt++;
    if (error_status !== 4'h0) begin err_cnt++; $display("FAIL reset_err: got %h want 0", error_status); end
    for (int f = 0; f < 4; f++) begin
      host_sel = 8'(f);
      #1;
      vec_cnt++;
      if (host_count !== 5'd0) begin err_cnt++; $display("FAIL reset_count[%0d]: got %0d want 0", f, host_count); end
    end
    wb_rst = 1'b0;
  endtask

  task automatic test_fifo_order;
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      host_op(1'b1, 8'd2, vals[i]);
      vec_cnt++;
      if (host_ack !== 1'b1) begin err_cnt++; $display("FAIL push_ack[%0d]: got %b want 1", i, host_ack); end
      vec_cnt++;
      if (host_count !== 5'(i + 1)) begin err_cnt++; $display("FAIL push_count[%0d]: got %0d want %0d", i, host_count, i + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      eng_start(1'b0, 8'd2, 32'h0);
      vec_cnt++;
      if (file_active !== 1'b1) begin err_cnt++; $display("FAIL rd_active_acc[%0d]: got %b want 1", i, file_active); end
      tick();
      vec_cnt++;
      if (file_active !== 1'b1) begin err_cnt++; $display("FAIL rd_active_done[%0d]: got %b want 1", i, file_active); end
      vec_cnt++;
      if (file_read_data !== vals[i]) begin err_cnt++; $display("FAIL rd_data[%0d]: got %h want %h", i, file_read_data, vals[i]); end
      tick();
      vec_cnt++;
      if (file_active !== 1'b0) begin err_cnt++; $display("FAIL rd_active_idle[%0d]: got %b want 0", i, file_active); end
      vec_cnt++;
      if (host_count !== 5'(2 - i)) begin err_cnt++; $display("FAIL rd_count[%0d]: got %0d want %0d", i, host_count, 2 - i); end
    end
    vec_cnt++;
    if (error_status !== 4'h0) begin err_cnt++; $display("FAIL fifo_err: got %h want 0", error_status); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) begin
      eng_start(1'b1, 8'd0, 32'h100 + 32'(i));
      tick();
      tick();
    end
    eng_start(1'b1, 8'd0, 32'hDEAD);
    tick();
    tick();
    host_sel = 8'd0;
    #1;
    vec_cnt++;
    if (host_count !== 5'd16) begin err_cnt++; $display("FAIL ovf_count: got %0d want 16", host_count); end
    vec_cnt++;
    if (error_status !== 4'b0001) begin err_cnt++; $display("FAIL ovf_err: got %b want 0001", error_status); end
    for (int i = 0; i < 16; i++) begin
      host_op(1'b0, 8'd0, 32'h0);
      vec_cnt++;
      if (host_rdata !== 32'h100 + 32'(i)) begin err_cnt++; $display("FAIL drain[%0d]: got %h want %h", i, host_rdata, 32'h100 + 32'(i)); end
    end
    host_op(1'b0, 8'd0, 32'h0);
    vec_cnt++;
    if (host_rdata !== 32'h0) begin err_cnt++; $display("FAIL udf_data: got %h want 0", host_rdata); end
    vec_cnt++;
    if (error_status !== 4'b0011) begin err_cnt++; $display("FAIL udf_err: got %b want 0011", error_status); end
    vec_cnt++;
    if (host_count !== 5'd0) begin err_cnt++; $display("FAIL udf_count: got %0d want 0", host_count); end
    // Underflow in the same cycle as a clear keeps its bit.
    error_clear = 1'b1;
    host_op(1'b0, 8'd0, 32'h0);
    error_clear = 1'b0;
    vec_cnt++;
    if (error_status !== 4'b0010) begin err_cnt++; $display("FAIL set_wins: got %b want 0010", error_status); end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    vec_cnt++;
    if (error_status !== 4'b0000) begin err_cnt++; $display("FAIL ovf_clear: got %b want 0000", error_status); end
  endtask

  task automatic test_bad_file;
    eng_start(1'b1, 8'd7, 32'hBEEF);
    vec_cnt++;
    if (file_active !== 1'b1) begin err_cnt++; $display("FAIL bad_active_acc: got %b want 1", file_active); end
    tick();
    vec_cnt++;
    if (file_active !== 1'b1) begin err_cnt++; $display("FAIL bad_active_done: got %b want 1", file_active); end
    tick();
    vec_cnt++;
    if (file_active !== 1'b0) begin err_cnt++; $display("FAIL bad_active_idle: got %b want 0", file_active); end
    vec_cnt++;
    if (error_status !== 4'b0100) begin err_cnt++; $display("FAIL bad_err: got %b want 0100", error_status); end
    for (int f = 0; f < 4; f++) begin
      host_sel = 8'(f);
      #1;
      vec_cnt++;
      if (host_count !== 5'd0) begin err_cnt++; $display("FAIL bad_count[%0d]: got %0d want 0", f, host_count); end
    end
    host_sel = 8'd7;
    #1;
    vec_cnt++;
    if (host_count !== 5'd0) begin err_cnt++; $display("FAIL bad_sel_count: got %0d want 0", host_count); end
    // Invalid read returns 0 (file_read_data still holds 0x33 beforehand).
    eng_start(1'b0, 8'd9, 32'h0);
    tick();
    vec_cnt++;
    if (file_read_data !== 32'h0) begin err_cnt++; $display("FAIL bad_rd_data: got %h want 0", file_read_data); end
    tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    vec_cnt++;
    if (error_status !== 4'b0000) begin err_cnt++; $display("FAIL bad_clear: got %b want 0000", error_status); end
  endtask

  task automatic test_contention;
    file_num = 8'd3; file_write = 1'b1; file_write_data = 32'hAA;
    host_sel = 8'd3; host_push = 1'b1; host_wdata = 32'hBB;
    tick();
    file_write = 1'b0;
    vec_cnt++;
    if (file_active !== 1'b1) begin err_cnt++; $display("FAIL cont_active: got %b want 1", file_active); end
    vec_cnt++;
    if (host_ack !== 1'b0) begin err_cnt++; $display("FAIL cont_ack0: got %b want 0", host_ack); end
    // Second engine request during ACCESS, with changed write data.
    file_read = 1'b1; file_write_data = 32'hFF;
    tick();
    file_read = 1'b0;
    vec_cnt++;
    if (error_status !== 4'b1000) begin err_cnt++; $display("FAIL cont_proto: got %b want 1000", error_status); end
    vec_cnt++;
    if (host_ack !== 1'b0) begin err_cnt++; $display("FAIL cont_ack1: got %b want 0", host_ack); end
    tick();
    vec_cnt++;
    if (host_ack !== 1'b0) begin err_cnt++; $display("FAIL cont_ack2: got %b want 0", host_ack); end
    tick();
    vec_cnt++;
    if (host_ack !== 1'b1) begin err_cnt++; $display("FAIL cont_ack3: got %b want 1", host_ack); end
    host_push = 1'b0;
    #1;
    vec_cnt++;
    if (host_count !== 5'd2) begin err_cnt++; $display("FAIL cont_count: got %0d want 2", host_count); end
    tick();
    vec_cnt++;
    if (host_ack !== 1'b0) begin err_cnt++; $display("FAIL cont_ack_pulse: got %b want 0", host_ack); end
    host_op(1'b0, 8'd3, 32'h0);
    vec_cnt++;
    if (host_rdata !== 32'hAA) begin err_cnt++; $display("FAIL cont_pop0: got %h want aa", host_rdata); end
    host_op(1'b0, 8'd3, 32'h0);
    vec_cnt++;
    if (host_rdata !== 32'hBB) begin err_cnt++; $display("FAIL cont_pop1: got %h want bb", host_rdata); end
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
  endtask

  task automatic test_back_to_back_wrap;
    for (int i = 0; i < 40; i++) begin
      host_op(1'b1, 8'd1, 32'h1000 + 32'(i));
      vec_cnt++;
      if (host_ack !== 1'b1 || host_count !== 5'd1) begin
        err_cnt++; $display("FAIL wrap_push[%0d]: ack %b count %0d want ack 1 count 1", i, host_ack, host_count);
      end
      host_op(1'b0, 8'd1, 32'h0);
      vec_cnt++;
      if (host_ack !== 1'b1 || host_rdata !== 32'h1000 + 32'(i) || host_count !== 5'd0) begin
        err_cnt++; $display("FAIL wrap_pop[%0d]: ack %b data %h count %0d want ack 1 data %h count 0",
                            i, host_ack, host_rdata, host_count, 32'h1000 + 32'(i));
      end
    end
    vec_cnt++;
    if (error_status !== 4'h0) begin err_cnt++; $display("FAIL wrap_err: got %b want 0000", error_status); end
  endtask

  task automatic test_reset_mid_access;
    host_op(1'b1, 8'd1, 32'h55);
    host_op(1'b1, 8'd1, 32'h66);
    vec_cnt++;
    if (host_count !== 5'd2) begin err_cnt++; $display("FAIL rst_pre_count: got %0d want 2", host_count); end
    eng_start(1'b0, 8'd1, 32'h0);
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    vec_cnt++;
    if (file_active !== 1'b0) begin err_cnt++; $display("FAIL rst_active: got %b want 0", file_active); end
    for (int f = 0; f < 4; f++) begin
      host_sel = 8'(f);
      #1;
      vec_cnt++;
      if (host_count !== 5'd0) begin err_cnt++; $display("FAIL rst_count[%0d]: got %0d want 0", f, host_count); end
    end
    eng_start(1'b0, 8'd1, 32'h0);
    tick();
    vec_cnt++;
    if (file_read_data !== 32'h0) begin err_cnt++; $display("FAIL rst_rd_data: got %h want 0", file_read_data); end
    vec_cnt++;
    if (error_status !== 4'b0010) begin err_cnt++; $display("FAIL rst_udf: got %b want 0010", error_status); end
    tick();
  endtask

  initial begin
    wb_rst = 1'b1;
    file_num = '0; file_write = 1'b0; file_read = 1'b0; file_write_data = '0;
    host_sel = '0; host_push = 1'b0; host_pop = 1'b0; host_wdata = '0;
    error_clear = 1'b0;
    test_reset();
    test_fifo_order();
    test_overflow();
    test_bad_file();
    test_contention();
    test_back_to_back_wrap();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1);
  end

endmodule
